dd_scanner: RTL and testbench
=============================

DD_SCANNER -- requirements
Module: dd_scanner

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1, meaning segment and gate outputs are driven active-low when 1 and active-high when 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wrValid, input, 1 bit: a new display word is offered.
REQ-005 SHALL have port wrReady, output, 1 bit: the block can accept a display word.
REQ-006 SHALL have port wrData, input, 32 bits: four 8-bit digit bytes; LED0=[31:24], LED1=[23:16], LED2=[15:8], LED3=[7:0].
REQ-007 SHALL have port period, input, 28 bits: clocks per digit slot; 0 selects 28'h3000.
REQ-008 SHALL have port segOut, output, 8 bits: segments a..g on [6:0], dp on [7].
REQ-009 SHALL have port gateOut, output, 4 bits: digit enables; bit i selects LEDi.
REQ-010 SHALL have port frameStart, output, 1 bit: one-cycle pulse when slot 0 begins.

Function
REQ-011 SHALL transfer a word only when wrValid and wrReady are both 1 in the same cycle; the word goes into a pending register.
REQ-012 SHALL use a two-state update FSM. EMPTY: wrReady=1; a transfer moves to PENDING. PENDING: wrReady=0; wrValid is ignored.
REQ-013 SHALL, in PENDING, copy the pending word into the display register on the first cycle of slot 0 and return to EMPTY. The update is therefore applied at a frame boundary and never mid-frame.
REQ-014 SHALL, when a transfer occurs on the same cycle that slot 0 begins, go to PENDING and apply the word at the next frame boundary, not the current one.
REQ-015 SHALL keep a slot counter that counts 0..P-1, where P is period (or 28'h3000 when period=0), sampled on the first cycle of each slot.
REQ-016 SHALL, when the counter equals P-1, reset the counter to 0 and advance the digit index 0->1->2->3->0 (wrap-around).
REQ-017 SHALL, with P=1, advance the digit every cycle.
REQ-018 SHALL have gateOut assert only bit[index] and segOut show the display byte for that index.
REQ-019 SHALL force gateOut to all-inactive on counter value 0 of every slot (one-cycle dead time against ghosting); segOut already shows the new digit in that cycle.
REQ-020 SHALL invert gateOut and segOut when ACTIVE_LOW=1; all internal logic is active-high.
REQ-021 SHALL register segOut and gateOut: output latency is one cycle from the index/counter update.
REQ-022 SHALL pulse frameStart on the cycle the counter is 0 and the index is 0.
REQ-023 SHALL ignore period changes mid-slot; a new value takes effect at the next slot start.

Reset
REQ-024 SHALL, on rst=1, set: counter 0, index 0, FSM EMPTY, display and pending registers 0, gateOut all inactive, segOut all inactive, frameStart 0, wrReady 0.
REQ-025 SHALL, on the first cycle after rst deasserts, restart slot 0 with frameStart=1 and wrReady=1.
REQ-026 SHALL, when rst is asserted during PENDING, discard the pending word.

Configuration
REQ-027 SHALL use macro DD_SCANNER_HEX_DECODE_EN.
- Defined: bits [3:0] of each byte are decoded as a hex digit 0-F to standard seven-segment patterns on segOut[6:0]; byte bit [7] drives dp; bits [6:4] are ignored.
- Not defined: the byte drives segOut raw (bit i = segment i).

Verification
REQ-028 SHALL cover: reset, then period=4 -> gate sequence LED0..LED3 repeating every 16 cycles; each slot starts with 1 dead cycle; frameStart every 16 cycles.
REQ-029 SHALL cover: wrData=32'h12345678 offered mid-frame -> accepted, wrReady low until the next frame start; old digits are held through the end of the frame; the new bytes appear from slot 0.
REQ-030 SHALL cover: wrValid held high over 3 words in PENDING -> only the first word is captured; the second is accepted after the frame boundary.
REQ-031 SHALL cover: period=0 -> slot length of 12288 cycles; period changed from 4 to 2 mid-slot -> current slot stays 4 cycles, the next is 2.
REQ-032 SHALL cover: with the macro defined, byte 8'h8A -> segments show "A" with dp on; without the macro -> segOut = ~8'h8A when ACTIVE_LOW=1.
REQ-033 SHALL cover: rst pulsed while PENDING -> outputs inactive, display register 0, pending word discarded, scanning restarts at LED0.

Source files
------------

// File: rtl/dd_scanner.sv
// Four-digit multiplexed LED scanner with a frame-synchronous display-word update FSM.
// Optional macro DD_SCANNER_HEX_DECODE_EN turns each byte's low nibble into a hex glyph (bit 7 = dp).
module dd_scanner #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrValid,
  output logic        wrReady,
  input  logic [31:0] wrData,
  input  logic [27:0] period,
  output logic [7:0]  segOut,
  output logic [3:0]  gateOut,
  output logic        frameStart
);

  typedef enum logic {EMPTY, PENDING} state_e;

  localparam logic [27:0] DEF_PERIOD = 28'h3000;
  localparam logic [7:0]  SEG_OFF    = {8{ACTIVE_LOW}};
  localparam logic [3:0]  GATE_OFF   = {4{ACTIVE_LOW}};

  state_e      st_q, st_d;
  logic [27:0] cnt_q, cnt_d;
  logic [27:0] per_q, per_d;
  logic [27:0] cur_p;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] disp_q, disp_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  gate_q, gate_d;
  logic [7:0]  byte_sel;
  logic [7:0]  seg_raw;
  logic [3:0]  gate_raw;
  logic        slot_start;
  logic        frame_begin;
  logic        wr_ready;
  logic        xfer;

`ifdef DD_SCANNER_HEX_DECODE_EN
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  logic unused_byte_bits;
  assign unused_byte_bits = ^byte_sel[6:4];
`endif

  assign slot_start  = (cnt_q == 28'd0);
  assign frame_begin = slot_start && (idx_q == 2'd0);
  assign wr_ready    = (st_q == EMPTY) && !rst;
  assign xfer        = wrValid && wr_ready;

  // Slot timing: the period is captured only when a slot starts.
  always_comb begin
    per_d = per_q;
    cur_p = per_q;
    if (slot_start) begin
      cur_p = (period == 28'd0) ? DEF_PERIOD : period;
      per_d = cur_p;
    end
    cnt_d = cnt_q + 28'd1;
    idx_d = idx_q;
    if (cnt_q == cur_p - 28'd1) begin
      cnt_d = 28'd0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Update FSM: a pending word lands only on the first cycle of slot 0.
  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    disp_d = disp_q;
    case (st_q)
      EMPTY: begin
        if (xfer) begin
          pend_d = wrData;
          st_d   = PENDING;
        end
      end
      PENDING: begin
        if (frame_begin) begin
          disp_d = pend_q;
          st_d   = EMPTY;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  // Output stage reads disp_d so a word applied at slot 0 is shown in that same slot.
  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = disp_d[31:24];
      2'd1:    byte_sel = disp_d[23:16];
      2'd2:    byte_sel = disp_d[15:8];
      default: byte_sel = disp_d[7:0];
    endcase
`ifdef DD_SCANNER_HEX_DECODE_EN
    seg_raw = {byte_sel[7], hex_seg(byte_sel[3:0])};
`else
    seg_raw = byte_sel;
`endif
    gate_raw = slot_start ? 4'b0000 : (4'b0001 << idx_q);
    seg_d    = seg_raw ^ SEG_OFF;
    gate_d   = gate_raw ^ GATE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= EMPTY;
      cnt_q  <= 28'd0;
      per_q  <= 28'd0;
      idx_q  <= 2'd0;
      pend_q <= 32'd0;
      disp_q <= 32'd0;
      seg_q  <= SEG_OFF;
      gate_q <= GATE_OFF;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      seg_q  <= seg_d;
      gate_q <= gate_d;
    end
  end

  assign segOut     = seg_q;
  assign gateOut    = gate_q;
  assign frameStart = frame_begin && !rst;
  assign wrReady    = wr_ready;

endmodule

// File: tb/tb_dd_scanner.sv
// Directed bench for dd_scanner (ACTIVE_LOW=1): scan order, frame-synchronous updates, period handling, reset.
module tb_dd_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrValid;
  logic        wrReady;
  logic [31:0] wrData;
  logic [27:0] period;
  logic [7:0]  segOut;
  logic [3:0]  gateOut;
  logic        frameStart;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef DD_SCANNER_HEX_DECODE_EN
  localparam logic [7:0] S00 = 8'hC0, S12 = 8'hA4, S34 = 8'h99, S56 = 8'h82;
  localparam logic [7:0] S78 = 8'h80, S8A = 8'h08, S4C = 8'hC6;
`else
  localparam logic [7:0] S00 = 8'hFF, S12 = 8'hED, S34 = 8'hCB, S56 = 8'hA9;
  localparam logic [7:0] S78 = 8'h87, S8A = 8'h75, S4C = 8'hB3;
`endif

  dd_scanner #(.ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .period(period), .segOut(segOut), .gateOut(gateOut), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) next();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Expected active-low gate in cycle n of a period-4 scan started at cycle 0.
  function automatic logic [3:0] gate_p4(input int n);
    int m;
    m = (n - 1) % 16;
    if (m % 4 == 0) gate_p4 = 4'hF;
    else            gate_p4 = ~(4'b0001 << (m / 4));
  endfunction

  initial begin
    rst = 1'b1; wrValid = 1'b0; wrData = 32'd0; period = 28'd4;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_gate", gateOut, 4'hF);
    chk("rst_seg", segOut, 8'hFF);
    chk("rst_frame", frameStart, 1'b0);
    chk("rst_ready", wrReady, 1'b0);

    @(posedge clk); #1; rst = 1'b0; cyc = 0;
    smp();
    chk("rel_frame", frameStart, 1'b1);
    chk("rel_ready", wrReady, 1'b1);
    chk("rel_gate", gateOut, 4'hF);

    for (int n = 1; n <= 32; n++) begin
      goto(n); smp();
      chk($sformatf("scan_gate_%0d", n), gateOut, gate_p4(n));
      chk($sformatf("scan_frame_%0d", n), frameStart, (n % 16 == 0));
    end
    chk("scan_seg_blank", segOut, S00);

    goto(38); wrValid = 1'b1; wrData = 32'h12345678; smp();
    chk("w1_ready", wrReady, 1'b1);
    goto(39); wrValid = 1'b0; smp();
    chk("w1_busy", wrReady, 1'b0);
    goto(48); smp();
    chk("w1_old_held", segOut, S00);
    chk("w1_busy_fb", wrReady, 1'b0);
    goto(49); smp();
    chk("w1_led0_seg", segOut, S12);
    chk("w1_led0_dead", gateOut, 4'hF);
    chk("w1_ready_again", wrReady, 1'b1);
    goto(50); smp();
    chk("w1_led0_gate", gateOut, 4'hE);
    goto(53); smp(); chk("w1_led1_seg", segOut, S34);
    goto(58); smp(); chk("w1_led2_seg", segOut, S56);
    goto(62); smp(); chk("w1_led3_seg", segOut, S78);

    goto(64); wrValid = 1'b1; wrData = 32'h8A010203; smp();
    chk("hold_ready_fb", wrReady, 1'b1);
    chk("hold_frame", frameStart, 1'b1);
    goto(65); wrData = 32'h4C112233; smp();
    chk("hold_busy", wrReady, 1'b0);
    chk("hold_not_now", segOut, S12);
    goto(80); smp();
    chk("hold_busy_80", wrReady, 1'b0);
    goto(81); smp();
    chk("hold_first_word", segOut, S8A);
    chk("hold_ready_81", wrReady, 1'b1);
    goto(82); wrData = 32'hFFFFFFFF; smp();
    chk("hold_busy_82", wrReady, 1'b0);
    goto(83); wrValid = 1'b0;
    goto(96); smp(); chk("hold_frame_96", frameStart, 1'b1);
    goto(97); smp(); chk("hold_second_word", segOut, S4C);

    goto(98); period = 28'd2; smp();
    chk("per_ready", wrReady, 1'b1);
    goto(99);  smp(); chk("per_g99", gateOut, 4'hE);
    goto(100); smp(); chk("per_g100", gateOut, 4'hE);
    goto(101); smp(); chk("per_g101", gateOut, 4'hF);
    goto(102); smp(); chk("per_g102", gateOut, 4'hD);
    goto(103); smp(); chk("per_g103", gateOut, 4'hF);
    goto(104); smp(); chk("per_g104", gateOut, 4'hB); chk("per_f104", frameStart, 1'b0);
    goto(105); smp(); chk("per_g105", gateOut, 4'hF);
    goto(106); smp(); chk("per_g106", gateOut, 4'h7); chk("per_f106", frameStart, 1'b1);

    goto(107); period = 28'd1;
    goto(111); smp(); chk("p1_f111", frameStart, 1'b1);
    goto(112); smp(); chk("p1_f112", frameStart, 1'b0); chk("p1_g112", gateOut, 4'hF);
    goto(115); smp(); chk("p1_f115", frameStart, 1'b1);

    goto(116); period = 28'd0;
    goto(12403); smp(); chk("p0_g12403", gateOut, 4'hD);
    goto(12404); smp(); chk("p0_g12404", gateOut, 4'hD);
    goto(12405); smp(); chk("p0_g12405", gateOut, 4'hF);
    goto(12406); wrValid = 1'b1; wrData = 32'hDEADBEEF; smp();
    chk("p0_g12406", gateOut, 4'hB);
    chk("pr_ready", wrReady, 1'b1);
    goto(12407); wrValid = 1'b0; smp();
    chk("pr_busy", wrReady, 1'b0);
    goto(12408); rst = 1'b1; period = 28'd4; smp();
    chk("pr_rst_ready", wrReady, 1'b0);
    chk("pr_rst_frame", frameStart, 1'b0);
    goto(12409); smp();
    chk("pr_rst_gate", gateOut, 4'hF);
    chk("pr_rst_seg", segOut, 8'hFF);

    @(posedge clk); #1; rst = 1'b0; cyc = 0;
    smp();
    chk("pr_rel_frame", frameStart, 1'b1);
    chk("pr_rel_ready", wrReady, 1'b1);
    goto(2);  smp(); chk("pr_led0_gate", gateOut, 4'hE); chk("pr_disp_zero", segOut, S00);
    goto(16); smp(); chk("pr_frame_16", frameStart, 1'b1);
    goto(17); smp(); chk("pr_discarded", segOut, S00);
    goto(18); smp(); chk("pr_ready_18", wrReady, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
